sram_arbiter: RTL
=================

Name: sram_arbiter

Overview:
- Memory-side stage directly downstream of the DivMMC paging logic.
- Consumes the DivMMC map, ram, page and ramwr_mask outputs plus the 128K/ROM paging state, and resolves every CPU memory access to a 19-bit address in the 512K SRAM.
- Time-multiplexes that SRAM between CPU accesses and video fetches with a small strobe-sequencing FSM, and returns read data to the CPU bus mux.

Parameters:
- ROM_BASE, 19'h40000, base of the 64K system ROM area (4 x 16K pages).
- DIVROM_BASE, 19'h50000, base of the 8K DivMMC ROM.
- DIVRAM_BASE, 19'h60000, base of the 128K DivMMC RAM (16 x 8K pages).

Ports:
- clk28 in 1: system clock, 28 MHz.
- rst_n in 1: asynchronous active-low reset.
- bus modport: cpu_bus interface; uses a, d, mreq, rd, wr.
- div_map in 1: DivMMC mapped into 0000-3FFF.
- div_ram in 1: DivMMC area access targets DivMMC RAM.
- div_page in 4: DivMMC RAM page.
- div_ramwr_mask in 1: suppress CPU writes.
- rom_page in 2: system ROM page.
- ram_page in 4: bank mapped at C000-FFFF.
- vid_req in 1: video fetch request, level.
- vid_addr in 14: offset within the screen bank.
- vid_bank7 in 1: 1 selects bank 7, 0 selects bank 5.
- vid_ack out 1: one-cycle pulse, vid_data valid.
- vid_data out 8: fetched byte.
- sram_a out 19: SRAM address.
- sram_d_in in 8: SRAM data in.
- sram_d_out out 8: SRAM write data.
- sram_d_oe out 1: drive the SRAM data bus.
- sram_oe_n out 1: SRAM output enable, active low.
- sram_we_n out 1: SRAM write enable, active low.
- d_out out 8: CPU read data.
- d_out_active out 1: d_out valid for the CPU bus mux.

Behaviour:
- Reset: FSM to IDLE. sram_oe_n = sram_we_n = 1, sram_d_oe = 0, sram_a = 0. vid_ack = 0, vid_data = 0, d_out = 0, d_out_active = 0. cpu_done and last_grant cleared.
- A reset mid-access aborts immediately; no strobe may glitch low.
- CPU request: cpu_req = bus.mreq && (bus.rd || bus.wr) && !cpu_done.
  - cpu_done sets in RECOVER of a CPU access.
  - cpu_done clears on any cycle with !bus.mreq.
  - Result: exactly one SRAM access per MREQ assertion.
- Address map, evaluated combinationally and latched into sram_a when leaving IDLE:
  - a[15:13]=000, div_map && !div_ram: DIVROM_BASE + a[12:0].
  - a[15:14]=00, div_map && div_ram: DIVRAM_BASE + {a[13] ? div_page : 4'd3, a[12:0]}.
  - a[15:14]=00, otherwise: ROM_BASE + {rom_page, a[13:0]}.
  - 01: {bank 5, a[13:0]}. 10: {bank 2, a[13:0]}. 11: {ram_page, a[13:0]}.
  - RAM bank n sits at n*16K from 0.
  - Video: {vid_bank7 ? 4'd7 : 4'd5, vid_addr}.
- Write blocking: a write is blocked if it targets ROM, DivMMC ROM, or has div_ramwr_mask=1. A blocked write still runs the full cycle with sram_we_n held 1.
- FSM: IDLE -> SETUP -> STROBE -> RECOVER -> IDLE, 4 clk28 per access.
  - IDLE: grant if vid_req or cpu_req. Latch sram_a, op type, and sram_d_out = bus.d.
  - SETUP: address stable, strobes high. sram_d_oe = 1 for an unblocked write.
  - STROBE: sram_oe_n = 0 for reads; sram_we_n = 0 for an unblocked write.
  - RECOVER: strobes high, address and sram_d_oe held (write hold). Read data is captured from sram_d_in at the STROBE->RECOVER edge.
- Results:
  - Video: vid_data updated, vid_ack pulses during RECOVER.
  - CPU read: d_out updated; d_out_active = bus.mreq && bus.rd && cpu_done.
- Arbitration: on a simultaneous vid_req and cpu_req, see Optional Feature. The loser stays pending, since requests are levels. vid_req held across a grant re-arbitrates in the next IDLE.
- Worst-case CPU latency is 8 clk28, which fits inside a Z80 MREQ at 3.5 MHz. No wait output.

Optional Feature:
- SRAM_VID_PRIORITY_EN defined: video always wins ties.
- Undefined: round-robin. last_grant toggles on each granted access and the side not granted last wins a tie.

Decomposition:
- Package common gains:
  - typedef sram_addr_t (19-bit).
  - Localparams BANK_SCREEN0 = 5, BANK_SCREEN1 = 7, BANK_MID = 2.
  - enum sram_state_t {IDLE, SETUP, STROBE, RECOVER}.
- Sub-module sram_addr_map: purely combinational address decode plus write-blocked flag, instantiated twice: CPU path, and video path through the bank fields.

Test Plan:
- CPU read 8000 with sram_d_in=5A: sram_a = 08000 (bank 2), oe_n low for exactly 1 cycle, d_out = 5A, d_out_active while mreq && rd, one access only.
- div_map=1, div_ram=1, div_page=6, write to 2345 data 77: sram_a = 60000 + 6*2000 + 0345 = 6C345, we_n low 1 cycle, sram_d_out = 77.
- div_ramwr_mask=1 write to 1000: 4-cycle cycle runs, sram_we_n stays 1; same outcome for a ROM write at 0000 with div_map=0.
- vid_req and cpu_req in the same cycle:
  - With SRAM_VID_PRIORITY_EN: video first (vid_ack), CPU access starts 4 cycles later.
  - Without it: alternating winners across repeated ties.
- rst_n low during STROBE of a write: sram_we_n = 1 and sram_d_oe = 0 asynchronously, FSM IDLE; after release, no spurious access without a new request.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// sram_arbiter_pkg: shared types and constants for the SRAM arbiter slice.
//   sram_addr_t      19-bit physical address into the 512K SRAM.
//   BANK_*           16K RAM bank numbers used by the fixed CPU windows and video.
//   sram_state_t     access sequencer states (IDLE -> SETUP -> STROBE -> RECOVER).
//   bank_addr()      builds the SRAM address of an offset within a 16K RAM bank.
package sram_arbiter_pkg;

   typedef logic [18:0] sram_addr_t;

   localparam logic [3:0] BANK_SCREEN0 = 4'd5;
   localparam logic [3:0] BANK_SCREEN1 = 4'd7;
   localparam logic [3:0] BANK_MID     = 4'd2;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETUP   = 2'd1,
      STROBE  = 2'd2,
      RECOVER = 2'd3
   } sram_state_t;

   // RAM bank n occupies n*16K upwards from SRAM address 0.
   function automatic sram_addr_t bank_addr(input logic [3:0] bank, input logic [13:0] offset);
      return {1'b0, bank, offset};
   endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// cpu_bus: Z80-side memory bus as seen by the SRAM arbiter.
//   a     CPU address
//   d     CPU write data
//   mreq  memory request (active high here)
//   rd    read strobe
//   wr    write strobe
// Modports: master drives the bus (CPU / testbench), slave observes it (arbiter).
interface cpu_bus;
   logic [15:0] a;
   logic [7:0]  d;
   logic        mreq;
   logic        rd;
   logic        wr;

   modport master (output a, output d, output mreq, output rd, output wr);
   modport slave  (input  a, input  d, input  mreq, input  rd, input  wr);
endinterface

// File: rtl/sram_arbiter_addr_map.sv
// sram_addr_map: purely combinational CPU address decode into the 512K SRAM.
//   a               16-bit CPU address
//   div_map         DivMMC mapped into 0000-3FFF
//   div_ram         DivMMC area access targets DivMMC RAM
//   div_page        DivMMC RAM page for 2000-3FFF
//   div_ramwr_mask  suppress writes
//   rom_page        system ROM page
//   ram_page        bank mapped at C000-FFFF
//   addr            resolved SRAM address
//   wr_blocked      a write to this address must not strobe the SRAM
// The video path reuses this block by presenting its offset in the C000 window
// with the screen bank on ram_page.
module sram_addr_map
   import sram_arbiter_pkg::*;
#(
   parameter sram_addr_t ROM_BASE    = 19'h40000,
   parameter sram_addr_t DIVROM_BASE = 19'h50000,
   parameter sram_addr_t DIVRAM_BASE = 19'h60000
) (
   input  logic [15:0] a,
   input  logic        div_map,
   input  logic        div_ram,
   input  logic [3:0]  div_page,
   input  logic        div_ramwr_mask,
   input  logic [1:0]  rom_page,
   input  logic [3:0]  ram_page,
   output sram_addr_t  addr,
   output logic        wr_blocked
);

   logic rom_target;

   always_comb begin
      addr       = '0;
      rom_target = 1'b0;
      if (a[15:13] == 3'b000 && div_map && !div_ram) begin
         addr       = DIVROM_BASE + {6'd0, a[12:0]};
         rom_target = 1'b1;
      end else if (a[15:14] == 2'b00 && div_map && div_ram) begin
         // 2000-3FFF follows div_page; 0000-1FFF is fixed to DivMMC page 3.
         addr = DIVRAM_BASE + {2'd0, (a[13] ? div_page : 4'd3), a[12:0]};
      end else if (a[15:14] == 2'b00) begin
         addr       = ROM_BASE + {3'd0, rom_page, a[13:0]};
         rom_target = 1'b1;
      end else begin
         unique case (a[15:14])
            2'b01:   addr = bank_addr(BANK_SCREEN0, a[13:0]);
            2'b10:   addr = bank_addr(BANK_MID, a[13:0]);
            default: addr = bank_addr(ram_page, a[13:0]);
         endcase
      end
      wr_blocked = rom_target || div_ramwr_mask;
   end

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares the 512K SRAM between CPU accesses and video fetches.
// Each access takes four clk28 cycles (IDLE, SETUP, STROBE, RECOVER); every
// SRAM-facing output is registered so strobes cannot glitch.
// Ports:
//   clk28, rst_n       clock, asynchronous active-low reset
//   bus                cpu_bus slave modport (a, d, mreq, rd, wr)
//   div_*              DivMMC paging state (map, ram, page, ramwr_mask)
//   rom_page, ram_page 128K/ROM paging state
//   vid_req/addr/bank7 video fetch request (level), offset and screen select
//   vid_ack, vid_data  one-cycle ack with the fetched byte
//   sram_*             SRAM address, data and active-low strobes
//   d_out, d_out_active CPU read data for the bus mux
// Build option: define SRAM_VID_PRIORITY_EN to make video win every tie;
// otherwise ties alternate round-robin.
module sram_arbiter
   import sram_arbiter_pkg::*;
#(
   parameter sram_addr_t ROM_BASE    = 19'h40000,
   parameter sram_addr_t DIVROM_BASE = 19'h50000,
   parameter sram_addr_t DIVRAM_BASE = 19'h60000
) (
   input  logic        clk28,
   input  logic        rst_n,
   cpu_bus.slave       bus,
   input  logic        div_map,
   input  logic        div_ram,
   input  logic [3:0]  div_page,
   input  logic        div_ramwr_mask,
   input  logic [1:0]  rom_page,
   input  logic [3:0]  ram_page,
   input  logic        vid_req,
   input  logic [13:0] vid_addr,
   input  logic        vid_bank7,
   output logic        vid_ack,
   output logic [7:0]  vid_data,
   output sram_addr_t  sram_a,
   input  logic [7:0]  sram_d_in,
   output logic [7:0]  sram_d_out,
   output logic        sram_d_oe,
   output logic        sram_oe_n,
   output logic        sram_we_n,
   output logic [7:0]  d_out,
   output logic        d_out_active
);

   sram_state_t state;
   sram_addr_t  cpu_addr;
   sram_addr_t  vid_sram_addr;
   logic        cpu_blocked;
   logic        vid_blocked;
   logic        cpu_done;
   logic        cpu_req;
   logic        grant_vid;
   logic        grant_cpu;
   logic        op_vid;
   logic        op_wr;
   logic        op_blocked;
`ifndef SRAM_VID_PRIORITY_EN
   logic        last_grant_vid;
`endif

   sram_addr_map #(
      .ROM_BASE    (ROM_BASE),
      .DIVROM_BASE (DIVROM_BASE),
      .DIVRAM_BASE (DIVRAM_BASE)
   ) u_cpu_map (
      .a              (bus.a),
      .div_map        (div_map),
      .div_ram        (div_ram),
      .div_page       (div_page),
      .div_ramwr_mask (div_ramwr_mask),
      .rom_page       (rom_page),
      .ram_page       (ram_page),
      .addr           (cpu_addr),
      .wr_blocked     (cpu_blocked)
   );

   sram_addr_map #(
      .ROM_BASE    (ROM_BASE),
      .DIVROM_BASE (DIVROM_BASE),
      .DIVRAM_BASE (DIVRAM_BASE)
   ) u_vid_map (
      .a              ({2'b11, vid_addr}),
      .div_map        (1'b0),
      .div_ram        (1'b0),
      .div_page       (4'd0),
      .div_ramwr_mask (1'b0),
      .rom_page       (2'd0),
      .ram_page       (vid_bank7 ? BANK_SCREEN1 : BANK_SCREEN0),
      .addr           (vid_sram_addr),
      .wr_blocked     (vid_blocked)
   );

   // cpu_done suppresses a second access within the same MREQ.
   assign cpu_req = bus.mreq && (bus.rd || bus.wr) && !cpu_done;

`ifdef SRAM_VID_PRIORITY_EN
   assign grant_vid = vid_req;
`else
   assign grant_vid = vid_req && (!cpu_req || !last_grant_vid);
`endif
   assign grant_cpu = cpu_req && !grant_vid;

   assign d_out_active = bus.mreq && bus.rd && cpu_done;

   always_ff @(posedge clk28 or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         sram_a     <= '0;
         sram_d_out <= '0;
         sram_d_oe  <= 1'b0;
         sram_oe_n  <= 1'b1;
         sram_we_n  <= 1'b1;
         vid_ack    <= 1'b0;
         vid_data   <= '0;
         d_out      <= '0;
         cpu_done   <= 1'b0;
         op_vid     <= 1'b0;
         op_wr      <= 1'b0;
         op_blocked <= 1'b0;
`ifndef SRAM_VID_PRIORITY_EN
         last_grant_vid <= 1'b0;
`endif
      end else begin
         vid_ack <= 1'b0;
         unique case (state)
            IDLE: begin
               if (grant_vid || grant_cpu) begin
                  sram_a     <= grant_vid ? vid_sram_addr : cpu_addr;
                  op_vid     <= grant_vid;
                  op_wr      <= !grant_vid && bus.wr;
                  op_blocked <= grant_vid ? vid_blocked : cpu_blocked;
                  sram_d_out <= bus.d;
                  sram_d_oe  <= !grant_vid && bus.wr && !cpu_blocked;
`ifndef SRAM_VID_PRIORITY_EN
                  last_grant_vid <= grant_vid;
`endif
                  state <= SETUP;
               end
            end
            SETUP: begin
               sram_oe_n <= op_wr;
               sram_we_n <= !(op_wr && !op_blocked);
               state     <= STROBE;
            end
            STROBE: begin
               sram_oe_n <= 1'b1;
               sram_we_n <= 1'b1;
               if (!op_wr) begin
                  if (op_vid) vid_data <= sram_d_in;
                  else        d_out    <= sram_d_in;
               end
               if (op_vid) vid_ack  <= 1'b1;
               else        cpu_done <= 1'b1;
               state <= RECOVER;
            end
            default: begin
               // Data bus stays driven through RECOVER for write hold time.
               sram_d_oe <= 1'b0;
               state     <= IDLE;
            end
         endcase
         if (!bus.mreq) cpu_done <= 1'b0;
      end
   end

endmodule
